classifier_flow_aging: RTL and testbench

//  Background sweeper on the flow expiry-time table in the classifier flow memory.
//  - Walks every FID slot in turn through the flow_etime read port.
//  - Compares each stored time against current_time.
//  - Emits the FID of each idle flow on a valid/ready port, consumed by the flow-delete logic.
//  - Sits directly downstream of the flow memory's etime RAM; shares nothing else with it.

---
 rtl/classifier_flow_aging.sv | 161 ++++++++++++++++
 tb/tb_classifier_flow_aging.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_flow_aging.sv
// Background sweeper over the flow expiry-time table.
// Walks every FID, compares its stored time with current_time, emits idle FIDs.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   aging_en            level enable; 1 = scan continuously
//   aging_timeout       age threshold in time ticks
//   scan_gap            idle cycles inserted before each read
//   current_time        free-running time (low TIME_NBITS bits used)
//   flow_etime_rd/raddr read strobe (1-cycle pulse) and FID address
//   flow_etime_ack/rdata read data valid and stored last-seen time (0 = empty)
//   aged_valid/fid/ready aged-FID handshake towards flow-delete logic
//   scan_done           1-cycle pulse when the last entry of a scan finishes
//   aged_count          FIDs emitted in the last completed scan, saturating
module classifier_flow_aging #(
  parameter int DEPTH_NBITS     = 12,
  parameter int TIME_NBITS      = 16,
  parameter int GAP_NBITS       = 8,
  parameter int CNT_NBITS       = 16,
  parameter int REAL_TIME_NBITS = 32,
  parameter int FID_NBITS       = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       aging_en,
  input  logic [TIME_NBITS-1:0]      aging_timeout,
  input  logic [GAP_NBITS-1:0]       scan_gap,
  input  logic [REAL_TIME_NBITS-1:0] current_time,
  output logic                       flow_etime_rd,
  output logic [DEPTH_NBITS-1:0]     flow_etime_raddr,
  input  logic                       flow_etime_ack,
  input  logic [TIME_NBITS-1:0]      flow_etime_rdata,
  output logic                       aged_valid,
  output logic [FID_NBITS-1:0]       aged_fid,
  input  logic                       aged_ready,
  output logic                       scan_done,
  output logic [CNT_NBITS-1:0]       aged_count
);

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    READ,
    WAIT,
    CHECK,
    EMIT
  } state_t;

  state_t                 state;
  logic [DEPTH_NBITS-1:0] addr;
  logic [GAP_NBITS-1:0]   gap_cnt;
  logic [TIME_NBITS-1:0]  etime_q;
  logic [CNT_NBITS-1:0]   run_cnt;

  logic [TIME_NBITS-1:0]  age;
  logic                   is_aged;
  logic                   accept;
  logic                   adv;
  logic                   last;
  logic [CNT_NBITS-1:0]   cnt_next;

  // Upper time bits are intentionally ignored (age is modulo 2^TIME_NBITS).
  logic                   time_unused;
  assign time_unused = ^current_time;

  // Age wraps naturally in TIME_NBITS arithmetic.
  assign age     = current_time[TIME_NBITS-1:0] - etime_q;
  assign is_aged = (etime_q != '0) && (age > aging_timeout);
  assign accept  = (state == EMIT) && aged_ready;
  assign adv     = ((state == CHECK) && !is_aged) || accept;
  assign last    = &addr;

  // Count including an accept in the advancing cycle, saturating.
  always_comb begin
    cnt_next = run_cnt;
    if (accept && !(&run_cnt))
      cnt_next = run_cnt + CNT_NBITS'(1);
  end

  assign flow_etime_raddr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      gap_cnt       <= '0;
      etime_q       <= '0;
      run_cnt       <= '0;
      flow_etime_rd <= 1'b0;
      aged_valid    <= 1'b0;
      aged_fid      <= '0;
      scan_done     <= 1'b0;
      aged_count    <= '0;
    end else begin
      scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (aging_en) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (!aging_en) begin
            state   <= IDLE;
            addr    <= '0;
            run_cnt <= '0;
          end else if (gap_cnt == scan_gap) begin
            state         <= READ;
            flow_etime_rd <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_NBITS'(1);
          end
        end
        READ: begin
          flow_etime_rd <= 1'b0;
          state         <= WAIT;
        end
        WAIT: begin
          if (flow_etime_ack) begin
            etime_q <= flow_etime_rdata;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (is_aged) begin
            state      <= EMIT;
            aged_valid <= 1'b1;
            aged_fid   <= FID_NBITS'(addr);
          end
        end
        EMIT: begin
          if (aged_ready)
            aged_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Move to the next entry; a mid-scan disable abandons the scan.
      if (adv) begin
        gap_cnt <= '0;
        if (last) begin
          scan_done  <= 1'b1;
          aged_count <= cnt_next;
          run_cnt    <= '0;
          addr       <= '0;
          state      <= aging_en ? GAP : IDLE;
        end else if (aging_en) begin
          addr    <= addr + DEPTH_NBITS'(1);
          run_cnt <= cnt_next;
          state   <= GAP;
        end else begin
          addr    <= '0;
          run_cnt <= '0;
          state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_classifier_flow_aging.sv
// Testbench for classifier_flow_aging.
// Table-driven scans plus hand-written corner sequences, scoreboard on aged FIDs.
module tb_classifier_flow_aging;

  logic        clk = 1'b0;
  logic        rst;
  logic        aging_en;
  logic [15:0] aging_timeout;
  logic [7:0]  scan_gap;
  logic [31:0] current_time;
  logic        rd;
  logic [1:0]  raddr;
  logic        ack = 1'b0;
  logic [15:0] rdata = '0;
  logic        aged_valid;
  logic [7:0]  aged_fid;
  logic        aged_ready;
  logic        scan_done;
  logic [15:0] aged_count;

  logic [15:0] mem [4];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int sd_cnt  = 0;
  int rd_cyc[$];
  int exp_q[$];

  classifier_flow_aging #(
    .DEPTH_NBITS(2),
    .TIME_NBITS(16),
    .GAP_NBITS(8),
    .CNT_NBITS(16),
    .REAL_TIME_NBITS(32),
    .FID_NBITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .aging_en(aging_en),
    .aging_timeout(aging_timeout),
    .scan_gap(scan_gap),
    .current_time(current_time),
    .flow_etime_rd(rd),
    .flow_etime_raddr(raddr),
    .flow_etime_ack(ack),
    .flow_etime_rdata(rdata),
    .aged_valid(aged_valid),
    .aged_fid(aged_fid),
    .aged_ready(aged_ready),
    .scan_done(scan_done),
    .aged_count(aged_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Etime RAM model: data one cycle after the read strobe.
  always @(posedge clk) begin
    ack   <= rd;
    rdata <= mem[raddr];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: read times, scan_done pulses, accepted FIDs.
  always @(negedge clk) begin
    #2;
    if (rd) rd_cyc.push_back(cyc);
    if (scan_done) sd_cnt++;
    if (aged_valid && aged_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fid: got %0h want none", aged_fid);
      end else begin
        check("aged_fid", aged_fid, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_rd(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (aged_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_nrd(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_cyc.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic set_mem(input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    mem[0] = e0;
    mem[1] = e1;
    mem[2] = e2;
    mem[3] = e3;
  endtask

  typedef struct packed {
    logic [3:0][15:0] et;
    logic [31:0]      tm;
    logic [15:0]      to;
    logic [3:0]       mask;
    logic [15:0]      cnt;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [31:0] tm, input logic [15:0] to,
                              input logic [3:0] mask, input logic [15:0] cnt);
    vec_t v;
    v.et   = {e3, e2, e1, e0};
    v.tm   = tm;
    v.to   = to;
    v.mask = mask;
    v.cnt  = cnt;
    return v;
  endfunction

  vec_t vecs[5];

  initial begin
    bit ok;
    int n;
    int bad;
    int sd0;

    rst           = 1'b1;
    aging_en      = 1'b0;
    aging_timeout = '0;
    scan_gap      = '0;
    current_time  = '0;
    aged_ready    = 1'b1;
    set_mem(0, 0, 0, 0);

    vecs[0] = mk(16'd0, 16'd100, 16'd500, 16'd0,
                 32'd1000, 16'd600, 4'b0010, 16'd1);
    vecs[1] = mk(16'd0, 16'd0, 16'hFFF0, 16'd0,
                 32'h10, 16'h10, 4'b0100, 16'd1);
    vecs[2] = mk(16'd0, 16'd0, 16'h0100, 16'd0,
                 32'h200, 16'h100, 4'b0000, 16'd0);
    vecs[3] = mk(16'hFFFF, 16'h8000, 16'd5, 16'd0,
                 32'h0001_0005, 16'h7000, 4'b0010, 16'd1);
    vecs[4] = mk(16'd1, 16'd2, 16'd3, 16'd4,
                 32'd100, 16'd10, 4'b1111, 16'd4);

    repeat (3) @(negedge clk);
    check("rst_rd", rd, 0);
    check("rst_valid", aged_valid, 0);
    check("rst_done", scan_done, 0);
    check("rst_count", aged_count, 0);
    check("rst_raddr", raddr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven full scans.
    for (int v = 0; v < 5; v++) begin
      set_mem(vecs[v].et[0], vecs[v].et[1], vecs[v].et[2], vecs[v].et[3]);
      current_time  = vecs[v].tm;
      aging_timeout = vecs[v].to;
      for (int f = 0; f < 4; f++)
        if (vecs[v].mask[f]) exp_q.push_back(f);
      aging_en = 1'b1;
      wait_done(200, ok);
      check($sformatf("v%0d_scan_done", v), ok, 1);
      aging_en = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_count", v), aged_count, vecs[v].cnt);
      check($sformatf("v%0d_q_empty", v), exp_q.size(), 0);
      exp_q.delete();
    end

    // Disable during WAIT of FID1.
    set_mem(0, 100, 0, 0);
    current_time  = 32'd1000;
    aging_timeout = 16'd600;
    sd0 = sd_cnt;
    exp_q.push_back(1);
    aging_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd && raddr == 2'd1) begin
        ok = 1;
        break;
      end
    end
    check("drop_rd1_seen", ok, 1);
    @(negedge clk);
    aging_en = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_emitted", exp_q.size(), 0);
    check("drop_raddr", raddr, 0);
    check("drop_no_done", sd_cnt, sd0);
    check("drop_count_kept", aged_count, 4);
    n = rd_cyc.size();
    repeat (5) @(negedge clk);
    check("drop_idle_no_rd", rd_cyc.size(), n);
    exp_q.push_back(1);
    aging_en = 1'b1;
    wait_rd(50, ok);
    check("reen_rd", ok, 1);
    check("reen_raddr", raddr, 0);
    wait_done(200, ok);
    check("reen_done", ok, 1);
    aging_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reen_count", aged_count, 1);
    check("reen_q_empty", exp_q.size(), 0);
    exp_q.delete();

    // Backpressure: consumer not ready for 20 cycles.
    aged_ready = 1'b0;
    exp_q.push_back(1);
    aging_en = 1'b1;
    wait_valid(100, ok);
    check("bp_valid", ok, 1);
    n = rd_cyc.size();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(aged_valid && aged_fid == 8'd1)) bad++;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_no_rd", rd_cyc.size(), n);
    aged_ready = 1'b1;
    wait_rd(50, ok);
    check("bp_rd_resume", ok, 1);
    check("bp_raddr", raddr, 2);
    wait_done(200, ok);
    check("bp_done", ok, 1);
    aging_en = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_count", aged_count, 1);
    check("bp_q_empty", exp_q.size(), 0);
    exp_q.delete();

    // Read spacing with nothing aging.
    set_mem(0, 0, 0, 0);
    scan_gap = 8'd3;
    rd_cyc.delete();
    aging_en = 1'b1;
    wait_nrd(3, 100, ok);
    check("gap3_rds", ok, 1);
    if (ok) begin
      check("gap3_space0", rd_cyc[1] - rd_cyc[0], 7);
      check("gap3_space1", rd_cyc[2] - rd_cyc[1], 7);
    end
    aging_en = 1'b0;
    repeat (20) @(negedge clk);
    scan_gap = 8'd0;
    rd_cyc.delete();
    aging_en = 1'b1;
    wait_nrd(3, 100, ok);
    check("gap0_rds", ok, 1);
    if (ok) begin
      check("gap0_space0", rd_cyc[1] - rd_cyc[0], 4);
      check("gap0_space1", rd_cyc[2] - rd_cyc[1], 4);
    end
    aging_en = 1'b0;
    repeat (20) @(negedge clk);

    // Reset while an aged FID is pending.
    set_mem(0, 100, 0, 0);
    aged_ready = 1'b0;
    aging_en   = 1'b1;
    wait_valid(100, ok);
    check("rstemit_valid", ok, 1);
    check("rstemit_count_pre", aged_count, 1);
    rst      = 1'b1;
    aging_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstemit_valid0", aged_valid, 0);
    check("rstemit_rd0", rd, 0);
    check("rstemit_count0", aged_count, 0);
    check("rstemit_raddr0", raddr, 0);
    n   = rd_cyc.size();
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (aged_valid) bad++;
    end
    check("rstemit_idle_valid", bad, 0);
    check("rstemit_idle_rd", rd_cyc.size(), n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
